// File: rtl/spi_master_byte.sv
// Byte-oriented SPI master: all four CPOL/CPHA modes, MSB first, DIV clk cycles per
// mclk half-period, and multi-byte bursts under one select via the HOLD state.
module spi_master_byte #(
    parameter int unsigned DIV = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cpol,
    input  logic       cpha,
    input  logic       start,
    input  logic       last,
    input  logic [7:0] din,
    output logic [7:0] dout,
    output logic       done,
    output logic       busy,
    output logic       mselect,
    output logic       mclk,
    output logic       mosi,
    input  logic       miso
);

    localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int unsigned EW = 5;

    typedef enum logic [2:0] {IDLE, SETUP, XFER, HOLD, GAP} state_t;

    state_t        state, state_next;
    logic [CW-1:0] cnt;
    logic [EW-1:0] ecnt;
    logic          cpol_r, cpha_r, last_r;
    logic [7:0]    tx, rx;
    logic          miso_q;

    logic accept, tick, edge_now, leading, samp_edge, shift_edge, cpha_eff;

    // ecnt counts issued mclk edges; 16 = last edge out, 17 = done cycle
    always_comb begin
        state_next = state;
        accept     = 1'b0;
        edge_now   = 1'b0;
        tick       = (cnt == CW'(DIV - 1));
        leading    = ~ecnt[0];
        cpha_eff   = (state == IDLE) ? cpha : cpha_r;
        case (state)
            IDLE, HOLD: begin
                if (start) begin
                    accept     = 1'b1;
                    state_next = SETUP;
                end
            end
            SETUP: begin
                edge_now = tick;
                if (tick) state_next = XFER;
            end
            XFER: begin
                edge_now = tick && (ecnt < EW'(16));
                if (ecnt == EW'(17)) state_next = last_r ? GAP : HOLD;
            end
            GAP: begin
                if (tick) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
        samp_edge  = edge_now && (cpha_r ? ~leading : leading);
        shift_edge = edge_now && (cpha_r ? leading : (~leading && (ecnt != EW'(15))));
    end

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt     <= '0;
            ecnt    <= '0;
            cpol_r  <= 1'b0;
            cpha_r  <= 1'b0;
            last_r  <= 1'b0;
            tx      <= '0;
            rx      <= '0;
            miso_q  <= 1'b0;
            dout    <= '0;
            done    <= 1'b0;
            busy    <= 1'b0;
            mselect <= 1'b1;
            mclk    <= 1'b0;
            mosi    <= 1'b0;
        end else begin
            done   <= 1'b0;
            miso_q <= miso;
            busy   <= (state_next == SETUP) || (state_next == XFER) || (state_next == GAP);

            if (accept || (state_next != state))
                cnt <= '0;
            else if ((state != IDLE) && (state != HOLD))
                cnt <= tick ? '0 : cnt + CW'(1);

            if (accept) begin
                last_r  <= last;
                ecnt    <= '0;
                mselect <= 1'b0;
                if (state == IDLE) begin
                    cpol_r <= cpol;
                    cpha_r <= cpha;
                    mclk   <= cpol;
                end
                // cpha=0 must present bit7 before the first (sampling) edge
                if (!cpha_eff) begin
                    mosi <= din[7];
                    tx   <= {din[6:0], 1'b0};
                end else begin
                    tx   <= din;
                end
            end

            if (edge_now) begin
                mclk <= ~mclk;
                ecnt <= ecnt + EW'(1);
            end
            if (samp_edge) rx <= {rx[6:0], miso_q};
            if (shift_edge) begin
                mosi <= tx[7];
                tx   <= {tx[6:0], 1'b0};
            end

            if ((state == XFER) && (ecnt == EW'(16))) begin
                ecnt <= EW'(17);
                done <= 1'b1;
                dout <= rx;
            end
            if ((state == XFER) && (ecnt == EW'(17)) && last_r)
                mselect <= 1'b1;
        end
    end

endmodule

// File: tb/tb_spi_master_byte.sv
// Testbench for spi_master_byte: a behavioural SPI slave on the bus returns queued
// bytes and collects what the master sends; each transfer is checked end to end.
module tb_spi_master_byte;

    localparam int unsigned DIV = 4;
    localparam int          LAT = 16 * DIV + 2;

    logic       clk = 1'b0, rst_n = 1'b0;
    logic       cpol = 1'b0, cpha = 1'b0, start = 1'b0, last = 1'b0, miso = 1'b0;
    logic [7:0] din = 8'h00;
    logic [7:0] dout;
    logic       done, busy, mselect, mclk, mosi;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    spi_master_byte #(.DIV(DIV)) dut (
        .clk(clk), .rst_n(rst_n), .cpol(cpol), .cpha(cpha), .start(start), .last(last),
        .din(din), .dout(dout), .done(done), .busy(busy), .mselect(mselect),
        .mclk(mclk), .mosi(mosi), .miso(miso)
    );

    // Slave model: mode is what the bench believes was latched at the last select fall
    logic       s_cpol = 1'b0, s_cpha = 1'b0;
    logic [7:0] s_q[$];
    logic [7:0] s_got[$];
    logic [7:0] s_byte = 8'h00, s_rx = 8'h00;
    int         s_k = 0, s_nsamp = 0, s_edges = 0, s_bad = 0;
    logic       s_loaded = 1'b0, s_prev_sel = 1'b1, s_prev_mclk = 1'b0;

    always @(negedge clk) begin
        if (s_prev_sel && !mselect) begin
            s_k = 0; s_nsamp = 0; s_loaded = 1'b0;
        end else if (!mselect && (mclk !== s_prev_mclk)) begin
            s_k++; s_edges++;
            if (s_k % 2 == 1) begin
                if (mclk !== ~s_cpol) s_bad++;
            end else if (mclk !== s_cpol) s_bad++;
            if ((s_k % 2 == 1) != s_cpha) begin
                s_rx = {s_rx[6:0], mosi};
                s_nsamp++;
                if (s_nsamp == 8) begin
                    s_got.push_back(s_rx);
                    s_nsamp = 0;
                end
            end else if (s_cpha) begin
                if (s_k == 1) s_byte = (s_q.size() > 0) ? s_q.pop_front() : 8'h00;
                miso = s_byte[7 - (s_k - 1) / 2];
            end else begin
                if (s_k < 16) miso = s_byte[7 - s_k / 2];
                else s_loaded = 1'b0;
            end
            if (s_k == 16) s_k = 0;
        end
        if (!mselect && !s_cpha && !s_loaded && (s_q.size() > 0)) begin
            s_byte   = s_q.pop_front();
            miso     = s_byte[7];
            s_loaded = 1'b1;
        end
        s_prev_sel  = mselect;
        s_prev_mclk = mclk;
    end

    task automatic do_byte(input logic [7:0] d, input logic l, input logic pol,
                           input logic pha, input logic [7:0] sret, input bit hammer);
        int n, lat, e0, gap;
        logic [7:0] got;
        logic from_idle;
        n = 0;
        while (busy === 1'b1 && n < 500) begin @(negedge clk); n++; end
        checks++;
        assert (busy === 1'b0) else begin
            errors++; $error("FAIL wait_idle busy=%b required 0", busy);
        end
        from_idle = mselect;
        if (from_idle) begin s_cpol = pol; s_cpha = pha; end
        s_q.push_back(sret);
        e0 = s_edges;
        start = 1'b1; din = d; last = l; cpol = pol; cpha = pha;
        @(negedge clk);
        if (!hammer) start = 1'b0;
        checks++;
        assert (busy === 1'b1 && mselect === 1'b0) else begin
            errors++; $error("FAIL accept busy=%b mselect=%b required 1/0", busy, mselect);
        end
        lat = 1;
        while (done !== 1'b1 && lat < LAT + 20) begin
            if (hammer) begin
                din = 8'($urandom); cpol = 1'($urandom); cpha = 1'($urandom); last = 1'($urandom);
            end
            @(negedge clk);
            lat++;
        end
        start = 1'b0;
        checks++;
        assert (lat === LAT) else begin
            errors++; $error("FAIL latency got=%0d required=%0d", lat, LAT);
        end
        checks++;
        assert (dout === sret) else begin
            errors++; $error("FAIL dout got=%h required=%h", dout, sret);
        end
        got = (s_got.size() > 0) ? s_got.pop_front() : 8'hxx;
        checks++;
        assert (got === d) else begin
            errors++; $error("FAIL mosi_byte got=%h required=%h", got, d);
        end
        checks++;
        assert (s_edges - e0 === 16) else begin
            errors++; $error("FAIL edge_count got=%0d required=16", s_edges - e0);
        end
        @(negedge clk);
        checks++;
        assert (done === 1'b0 && mclk === s_cpol) else begin
            errors++; $error("FAIL after_done done=%b mclk=%b required 0/%b", done, mclk, s_cpol);
        end
        if (l) begin
            checks++;
            assert (mselect === 1'b1) else begin
                errors++; $error("FAIL gap_select mselect=%b required 1", mselect);
            end
            gap = 0;
            while (busy === 1'b1 && gap < 50) begin gap++; @(negedge clk); end
            checks++;
            assert (gap === DIV && mselect === 1'b1) else begin
                errors++; $error("FAIL gap_len got=%0d mselect=%b required %0d/1", gap, mselect, DIV);
            end
        end else begin
            checks++;
            assert (mselect === 1'b0 && busy === 1'b0) else begin
                errors++; $error("FAIL hold mselect=%b busy=%b required 0/0", mselect, busy);
            end
        end
    endtask

    initial begin
        int n;
        bit saw_done;
        logic l;
        repeat (3) @(negedge clk);
        checks++;
        assert (mselect === 1'b1 && mclk === 1'b0 && mosi === 1'b0) else begin
            errors++; $error("FAIL reset_pins mselect=%b mclk=%b mosi=%b required 1/0/0", mselect, mclk, mosi);
        end
        checks++;
        assert (dout === 8'h00 && done === 1'b0 && busy === 1'b0) else begin
            errors++; $error("FAIL reset_out dout=%h done=%b busy=%b required 00/0/0", dout, done, busy);
        end
        rst_n = 1'b1;
        @(negedge clk);

        do_byte(8'hA5, 1'b1, 1'b0, 1'b0, 8'h3C, 1'b0);
        do_byte(8'h81, 1'b1, 1'b1, 1'b1, 8'h7E, 1'b0);
        do_byte(8'h12, 1'b0, 1'b0, 1'b0, 8'hE1, 1'b0);
        do_byte(8'h34, 1'b0, 1'b1, 1'b1, 8'h5D, 1'b0);
        do_byte(8'h56, 1'b1, 1'b1, 1'b0, 8'h0F, 1'b0);
        do_byte(8'($urandom), 1'b1, 1'b0, 1'b1, 8'($urandom), 1'b1);

        for (int i = 0; i < 10; i++) begin
            l = (i == 9) ? 1'b1 : 1'($urandom);
            do_byte(8'($urandom), l, 1'($urandom), 1'($urandom), 8'($urandom), 1'b0);
        end

        // Abort mid-byte with reset at the fifth mclk edge
        n = 0;
        while (busy === 1'b1 && n < 500) begin @(negedge clk); n++; end
        s_cpol = 1'b0; s_cpha = 1'b0;
        s_q.push_back(8'h99);
        start = 1'b1; din = 8'h5A; last = 1'b1; cpol = 1'b0; cpha = 1'b0;
        @(negedge clk);
        start = 1'b0;
        n = s_edges;
        saw_done = 1'b0;
        while (s_edges - n < 5 && s_edges - n >= 0 && (s_edges - n) < 5) begin
            if (done === 1'b1) saw_done = 1'b1;
            @(negedge clk);
            if ($time > 64'd2000000) break;
        end
        rst_n = 1'b0;
        @(negedge clk);
        checks++;
        assert (mselect === 1'b1 && mclk === 1'b0 && busy === 1'b0 && done === 1'b0) else begin
            errors++; $error("FAIL abort mselect=%b mclk=%b busy=%b done=%b required 1/0/0/0",
                             mselect, mclk, busy, done);
        end
        rst_n = 1'b1;
        repeat (80) begin
            @(negedge clk);
            if (done === 1'b1) saw_done = 1'b1;
        end
        checks++;
        assert (saw_done === 1'b0 && dout === 8'h00) else begin
            errors++; $error("FAIL abort_no_done saw_done=%b dout=%h required 0/00", saw_done, dout);
        end
        s_got.delete();
        do_byte(8'hC3, 1'b1, 1'b0, 1'b0, 8'($urandom), 1'b0);

        checks++;
        assert (s_bad === 0) else begin
            errors++; $error("FAIL edge_direction bad=%0d required 0", s_bad);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
